inst_buffer: RTL
================

Name: inst_buffer

Overview:
- Instruction queue between the fetch stage and the decode/issue stage.
- Absorbs dual-instruction fetch groups and presents up to two in-order instructions per cycle to decode.
- Consumes the pipeline controller's `flush_to_ibuffer` (drives `flush`) and decode-stall (gates `issue_en`).
- Back-pressures fetch through `buffer_full`.

Parameters:
- IB_DEPTH, 16, number of entries; power of two, >= 4.
- IB_AW, 4, log2(IB_DEPTH); pointer index width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset (`RstEnable`).
- flush  input  1  driven by `flush_to_ibuffer`; discards all contents.
- fetch_valid1  input  1  fetch slot 1 carries an instruction.
- fetch_valid2  input  1  fetch slot 2 carries an instruction; only honoured together with `fetch_valid1`.
- fetch_inst1  input  32  slot 1 instruction word.
- fetch_inst2  input  32  slot 2 instruction word.
- fetch_pc1  input  32  slot 1 PC.
- fetch_pc2  input  32  slot 2 PC.
- buffer_full  output  1  fewer than 2 free entries; fetch must not push.
- issue_en  input  1  decode accepts this cycle (low when decode is stalled).
- issue_mode  input  1  1 = take two instructions, 0 = take one.
- issue_ok1  output  1  head entry valid.
- issue_ok2  output  1  head+1 entry valid.
- issue_inst1  output  32  instruction at head.
- issue_inst2  output  32  instruction at head+1.
- issue_pc1  output  32  PC at head.
- issue_pc2  output  32  PC at head+1.
- buffer_count  output  IB_AW+1  occupied entries, 0..IB_DEPTH.

Behaviour:
- Storage:
  - Circular array of {inst, pc}.
  - Registers: head pointer, tail pointer (IB_AW bits, wrap modulo IB_DEPTH) and count (IB_AW+1 bits).
- Reset (`rst` = 1 at clock edge): head = tail = count = 0; the array need not be cleared.
  - Resulting outputs: `issue_ok1` = `issue_ok2` = 0, `buffer_full` = 0, `buffer_count` = 0.
  - Data outputs read as `ZeroWord` when their ok flag is 0.
- Outputs:
  - Combinational from registered state.
  - `issue_ok1` = (count >= 1); `issue_ok2` = (count >= 2).
  - inst/pc 1 and 2 = array[head] and array[head+1 mod DEPTH], or zero when the matching ok flag is 0.
  - `buffer_full` = (count > IB_DEPTH-2).
- Push:
  - Number pushed = 2 if `fetch_valid1` & `fetch_valid2`; 1 if `fetch_valid1` only; 0 otherwise. `fetch_valid2` without `fetch_valid1` pushes nothing.
  - Slot 1 is written at tail, slot 2 at tail+1; tail advances by the number pushed.
  - Push is suppressed entirely when `buffer_full` = 1 (data dropped; fetch is responsible for holding its PC).
- Pop:
  - Number popped = 0 if `issue_en` = 0.
  - Otherwise: 2 if `issue_mode` = 1 and `issue_ok2`; 1 if `issue_ok1`; else 0.
  - `issue_mode` = 1 with only one valid entry pops 1. Head advances by the number popped.
- Latency: a pushed instruction first appears on the issue outputs the cycle after the push edge; there is no same-cycle bypass.
- Simultaneous push and pop:
  - Pop is evaluated on pre-edge state.
  - count_next = count + pushed - popped.
  - Pushing into a full-minus-pop slot is still blocked by `buffer_full` computed on pre-edge count.
- Flush: priority rst > flush > push/pop.
  - `flush` = 1 sets head = tail = count = 0.
  - Same-cycle push and pop are discarded; outputs are invalid the next cycle.
- Wrap-around: pointers roll DEPTH-1 -> 0. A dual push or pop that straddles the wrap is legal.
- Invariant: count never exceeds IB_DEPTH and never goes below 0.

Optional Feature:
- IBUF_PERF_CNT_EN defined:
  - Adds outputs `perf_full_cycles` (32) and `perf_empty_cycles` (32).
  - Each increments once per cycle while `buffer_full` = 1 or count = 0 respectively.
  - Both reset to 0 on `rst` only (not on `flush`); they saturate at 32'hFFFFFFFF.
- IBUF_PERF_CNT_EN undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then push {0x24010001 @0xBFC00000, 0x24020002 @0xBFC00004} -> next cycle `issue_ok1` = `issue_ok2` = 1, `issue_pc1` = 0xBFC00000, `buffer_count` = 2.
- `issue_en` = 1, `issue_mode` = 1 with count 2 -> count 0 next cycle, `issue_ok1` = 0, `issue_inst1` = 0.
- 8 dual pushes with no pops (DEPTH 16) -> `buffer_full` = 1 once count reaches 15 or 16; a further push leaves count unchanged and contents intact.
- Fill to 10, then assert `flush` together with a dual push and dual pop -> count = 0, ok flags 0 next cycle; the following push lands and is read back correctly.
- Continuous single push with single-mode pops for 40 cycles, PCs incrementing by 4 -> issued PCs strictly sequential across pointer wrap, count steady at 1.
- count = 1 with `issue_mode` = 1 and `issue_en` = 1 -> pops exactly 1, `issue_ok2` was 0 during that cycle.

Source files
------------

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: circular queue of {inst, pc}, dual push / dual pop.
// Optional performance counters are enabled by defining IBUF_PERF_CNT_EN.
module inst_buffer #(
  parameter int IB_DEPTH = 16,
  parameter int IB_AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fetch_valid1,
  input  logic              fetch_valid2,
  input  logic [31:0]       fetch_inst1,
  input  logic [31:0]       fetch_inst2,
  input  logic [31:0]       fetch_pc1,
  input  logic [31:0]       fetch_pc2,
  output logic              buffer_full,
  input  logic              issue_en,
  input  logic              issue_mode,
  output logic              issue_ok1,
  output logic              issue_ok2,
  output logic [31:0]       issue_inst1,
  output logic [31:0]       issue_inst2,
  output logic [31:0]       issue_pc1,
  output logic [31:0]       issue_pc2,
`ifdef IBUF_PERF_CNT_EN
  output logic [31:0]       perf_full_cycles,
  output logic [31:0]       perf_empty_cycles,
`endif
  output logic [IB_AW:0]    buffer_count
);

  localparam logic [IB_AW:0] FULL_THRESH = (IB_AW+1)'(IB_DEPTH - 2);

  logic [31:0]      inst_mem_q [IB_DEPTH];
  logic [31:0]      pc_mem_q   [IB_DEPTH];
  logic [IB_AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [IB_AW-1:0] head_p1_s, tail_p1_s;
  logic [IB_AW:0]   count_q, count_d;
  logic [1:0]       push_n_s, pop_n_s;
  logic             wr1_en_s, wr2_en_s;

  assign head_p1_s = head_q + {{(IB_AW-1){1'b0}}, 1'b1};
  assign tail_p1_s = tail_q + {{(IB_AW-1){1'b0}}, 1'b1};

  // Issue-side view, derived purely from registered state
  always_comb begin
    buffer_full  = (count_q > FULL_THRESH);
    buffer_count = count_q;
    issue_ok1    = (count_q >= (IB_AW+1)'(1));
    issue_ok2    = (count_q >= (IB_AW+1)'(2));
    if (issue_ok1) begin
      issue_inst1 = inst_mem_q[head_q];
      issue_pc1   = pc_mem_q[head_q];
    end else begin
      issue_inst1 = 32'h0000_0000;
      issue_pc1   = 32'h0000_0000;
    end
    if (issue_ok2) begin
      issue_inst2 = inst_mem_q[head_p1_s];
      issue_pc2   = pc_mem_q[head_p1_s];
    end else begin
      issue_inst2 = 32'h0000_0000;
      issue_pc2   = 32'h0000_0000;
    end
  end

  // Push/pop sizing and next pointer state; flush wins over both
  always_comb begin
    if (!buffer_full && fetch_valid1) begin
      push_n_s = fetch_valid2 ? 2'd2 : 2'd1;
    end else begin
      push_n_s = 2'd0;
    end
    if (issue_en && issue_mode && issue_ok2) begin
      pop_n_s = 2'd2;
    end else if (issue_en && issue_ok1) begin
      pop_n_s = 2'd1;
    end else begin
      pop_n_s = 2'd0;
    end
    wr1_en_s = !flush && (push_n_s != 2'd0);
    wr2_en_s = !flush && (push_n_s == 2'd2);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + {{(IB_AW-2){1'b0}}, pop_n_s};
      tail_d  = tail_q + {{(IB_AW-2){1'b0}}, push_n_s};
      count_d = count_q + {{(IB_AW-1){1'b0}}, push_n_s} - {{(IB_AW-1){1'b0}}, pop_n_s};
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (!rst && wr1_en_s) begin
      inst_mem_q[tail_q] <= fetch_inst1;
      pc_mem_q[tail_q]   <= fetch_pc1;
    end
    if (!rst && wr2_en_s) begin
      inst_mem_q[tail_p1_s] <= fetch_inst2;
      pc_mem_q[tail_p1_s]   <= fetch_pc2;
    end
  end

`ifdef IBUF_PERF_CNT_EN
  logic [31:0] full_cnt_q, full_cnt_d, empty_cnt_q, empty_cnt_d;

  // Saturating occupancy counters; cleared by rst only, flush leaves them alone
  always_comb begin
    if (buffer_full && (full_cnt_q != 32'hFFFF_FFFF)) begin
      full_cnt_d = full_cnt_q + 32'd1;
    end else begin
      full_cnt_d = full_cnt_q;
    end
    if ((count_q == '0) && (empty_cnt_q != 32'hFFFF_FFFF)) begin
      empty_cnt_d = empty_cnt_q + 32'd1;
    end else begin
      empty_cnt_d = empty_cnt_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      full_cnt_q  <= 32'd0;
      empty_cnt_q <= 32'd0;
    end else begin
      full_cnt_q  <= full_cnt_d;
      empty_cnt_q <= empty_cnt_d;
    end
  end

  assign perf_full_cycles  = full_cnt_q;
  assign perf_empty_cycles = empty_cnt_q;
`endif

endmodule
